// File: rtl/dma_pkg.sv
// Shared types and encodings for the DMA controller: FSM states, config register
// select codes and CTRL bit positions.
package dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_REQ,
        ST_READ,
        ST_WRITE
    } dma_state_t;

    localparam logic [1:0] SEL_SRC  = 2'd0;
    localparam logic [1:0] SEL_DST  = 2'd1;
    localparam logic [1:0] SEL_CNT  = 2'd2;
    localparam logic [1:0] SEL_CTRL = 2'd3;

    localparam int CTRL_START = 0;
    localparam int CTRL_MODE  = 1;

    // Channel index width, never below one bit so a single-channel build still has a port.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dma_rr_arb.sv
// Round-robin arbiter over the active channels; combinational grant, pointer register.
// Search starts after the last served channel; pointer moves only when adv is pulsed.
module dma_rr_arb #(
    parameter int NCH = 4,
    parameter int IW  = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] req,
    input  logic           adv,
    output logic [NCH-1:0] gnt,
    output logic [IW-1:0]  idx
);

    logic [IW-1:0] ptr;
    logic          hit;

    always_comb begin
        gnt = '0;
        idx = '0;
        hit = 1'b0;
        for (int k = 1; k <= NCH; k++) begin
            if (!hit && req[(int'(ptr) + k) % NCH]) begin
                hit                          = 1'b1;
                gnt[(int'(ptr) + k) % NCH]   = 1'b1;
                idx                          = IW'((int'(ptr) + k) % NCH);
            end
        end
    end

    // Reset value points at the last channel so channel 0 is searched first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= IW'(NCH - 1);
        end else if (adv && hit) begin
            ptr <= idx;
        end
    end

endmodule

// File: rtl/dma_ctrl.sv
// Multi-channel memory-to-memory DMA: per-channel SRC/DST/CNT registers, round-robin
// arbitration, one word moved per READ/WRITE pair while the CPU grants the RAM bus.
module dma_ctrl
    import dma_pkg::*;
#(
    parameter int SZ  = 8,
    parameter int WSZ = 8,
    parameter int NCH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_we,
    input  logic [idx_w(NCH)-1:0]  cfg_ch,
    input  logic [1:0]             cfg_sel,
    input  logic [SZ-1:0]          cfg_wdata,
    output logic                   bus_req,
    input  logic                   bus_gnt,
    output logic [SZ-1:0]          ram_addr,
    output logic                   ram_w_notr,
    output logic [WSZ-1:0]         ram_wdata,
    input  logic [WSZ-1:0]         ram_rdata,
    output logic                   bus_own,
    output logic [NCH-1:0]         busy,
    output logic [NCH-1:0]         done
);

    localparam int CW = idx_w(NCH);

    dma_state_t     state, state_nxt;
    logic [SZ-1:0]  src [NCH];
    logic [SZ-1:0]  dst [NCH];
    logic [SZ-1:0]  cnt [NCH];
    logic [NCH-1:0] mode;
    logic [NCH-1:0] active;
    logic [WSZ-1:0] word_buf;
    logic [CW-1:0]  cur;

    logic [NCH-1:0] arb_gnt;
    logic [CW-1:0]  arb_idx;
    logic           arb_adv;
    logic           xfer_rd;
    logic           xfer_wr;
    logic           last_word;
    logic           cfg_ok;

    assign cfg_ok    = cfg_we && (int'(cfg_ch) < NCH) && !active[cfg_ch];
    assign last_word = (cnt[cur] == SZ'(1));
    assign busy      = active;

    dma_rr_arb #(
        .NCH (NCH),
        .IW  (CW)
    ) u_arb (
        .clk (clk),
        .rst (rst),
        .req (active),
        .adv (arb_adv),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        arb_adv    = 1'b0;
        xfer_rd    = 1'b0;
        xfer_wr    = 1'b0;
        bus_req    = 1'b0;
        bus_own    = 1'b0;
        ram_addr   = '0;
        ram_w_notr = 1'b0;
        ram_wdata  = '0;
        case (state)
            ST_IDLE: begin
                if (|active) state_nxt = ST_ARB;
            end
            ST_ARB: begin
                if (|arb_gnt) begin
                    arb_adv   = 1'b1;
                    state_nxt = ST_REQ;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_REQ: begin
                bus_req = 1'b1;
                if (bus_gnt) state_nxt = ST_READ;
            end
            ST_READ: begin
                bus_req  = 1'b1;
                bus_own  = 1'b1;
                ram_addr = src[cur];
                if (bus_gnt) begin
                    xfer_rd   = 1'b1;
                    state_nxt = ST_WRITE;
                end else begin
                    state_nxt = ST_REQ;
                end
            end
            ST_WRITE: begin
                bus_req   = 1'b1;
                bus_own   = 1'b1;
                ram_addr  = dst[cur];
                ram_wdata = word_buf;
                // A grant lost mid-word retries the whole word from READ.
                if (bus_gnt) begin
                    ram_w_notr = 1'b1;
                    xfer_wr    = 1'b1;
                    if (!last_word && mode[cur]) state_nxt = ST_READ;
                    else                         state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_REQ;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                src[i] <= '0;
                dst[i] <= '0;
                cnt[i] <= '0;
            end
            mode     <= '0;
            active   <= '0;
            done     <= '0;
            word_buf <= '0;
            cur      <= '0;
        end else begin
            done <= '0;
            if (arb_adv) cur <= arb_idx;
            if (xfer_rd) word_buf <= ram_rdata;
            if (cfg_ok) begin
                case (cfg_sel)
                    SEL_SRC: src[cfg_ch] <= cfg_wdata;
                    SEL_DST: dst[cfg_ch] <= cfg_wdata;
                    SEL_CNT: cnt[cfg_ch] <= cfg_wdata;
                    SEL_CTRL: begin
                        mode[cfg_ch] <= cfg_wdata[CTRL_MODE];
                        // Zero-length request completes at once without touching the bus.
                        if (cfg_wdata[CTRL_START]) begin
                            if (cnt[cfg_ch] != '0) active[cfg_ch] <= 1'b1;
                            else                   done[cfg_ch]   <= 1'b1;
                        end
                    end
                endcase
            end
            if (xfer_wr) begin
                src[cur] <= src[cur] + SZ'(1);
                dst[cur] <= dst[cur] + SZ'(1);
                cnt[cur] <= cnt[cur] - SZ'(1);
                if (last_word) begin
                    active[cur] <= 1'b0;
                    done[cur]   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dma_ctrl.sv
// Directed bench for dma_ctrl with a combinational-read RAM model and a write log.
module tb_dma_ctrl;
    import dma_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_we;
    logic [1:0] cfg_ch;
    logic [1:0] cfg_sel;
    logic [7:0] cfg_wdata;
    logic       bus_req;
    logic       bus_gnt;
    logic [7:0] ram_addr;
    logic       ram_w_notr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;
    logic       bus_own;
    logic [3:0] busy;
    logic [3:0] done;

    always #5 clk = ~clk;

    dma_ctrl #(.SZ(8), .WSZ(8), .NCH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_sel    (cfg_sel),
        .cfg_wdata  (cfg_wdata),
        .bus_req    (bus_req),
        .bus_gnt    (bus_gnt),
        .ram_addr   (ram_addr),
        .ram_w_notr (ram_w_notr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .bus_own    (bus_own),
        .busy       (busy),
        .done       (done)
    );

    // Source areas are never written, so reads return a fixed address-derived pattern.
    function automatic logic [7:0] pat(input logic [7:0] a);
        return {a[3:0], a[7:4]} ^ 8'h3C;
    endfunction

    assign ram_rdata = pat(ram_addr);

    logic [7:0] mem [256];
    logic [7:0] wa_q [$];
    logic [7:0] wd_q [$];
    int         done_cnt [4] = '{default: 0};
    int         wr_nognt = 0;

    always @(posedge clk) begin
        if (ram_w_notr) begin
            mem[ram_addr] <= ram_wdata;
            wa_q.push_back(ram_addr);
            wd_q.push_back(ram_wdata);
            if (!bus_gnt) wr_nognt++;
        end
        for (int i = 0; i < 4; i++) if (done[i]) done_cnt[i]++;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cfg(input logic [1:0] ch, input logic [1:0] sel, input logic [7:0] d);
        cfg_we    = 1'b1;
        cfg_ch    = ch;
        cfg_sel   = sel;
        cfg_wdata = d;
        @(negedge clk);
        cfg_we    = 1'b0;
    endtask

    task automatic setup(input logic [1:0] ch, input logic [7:0] s, input logic [7:0] d,
                         input logic [7:0] n);
        cfg(ch, SEL_SRC, s);
        cfg(ch, SEL_DST, d);
        cfg(ch, SEL_CNT, n);
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while ((busy != 4'b0 || bus_req) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(n < budget), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    logic [7:0] ea [4];
    logic [7:0] ed [4];
    int         pre;

    initial begin
        rst       = 1'b1;
        cfg_we    = 1'b0;
        cfg_ch    = '0;
        cfg_sel   = '0;
        cfg_wdata = '0;
        bus_gnt   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy",  32'(busy),       32'd0);
        chk("rst_done",  32'(done),       32'd0);
        chk("rst_req",   32'(bus_req),    32'd0);
        chk("rst_own",   32'(bus_own),    32'd0);
        chk("rst_addr",  32'(ram_addr),   32'd0);
        chk("rst_wnr",   32'(ram_w_notr), 32'd0);
        chk("rst_wdata", 32'(ram_wdata),  32'd0);
        rst = 1'b0;
        @(negedge clk);
        bus_gnt = 1'b1;

        // Block transfer on channel 0.
        setup(2'd0, 8'h10, 8'h80, 8'd3);
        clear_log();
        cfg(2'd0, SEL_CTRL, 8'h03);
        chk("t1_busy", 32'(busy[0]), 32'd1);
        wait_idle("t1_timeout", 40);
        chk("t1_nwr", 32'(wa_q.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            chk("t1_mem", 32'(mem[8'(8'h80 + i)]), 32'(pat(8'(8'h10 + i))));
        chk("t1_done", 32'(done_cnt[0]), 32'd1);
        chk("t1_req",  32'(bus_req),     32'd0);

        // Single-mode channels 1 and 2 must interleave.
        setup(2'd1, 8'h20, 8'h90, 8'd2);
        setup(2'd2, 8'h30, 8'hA0, 8'd2);
        clear_log();
        cfg(2'd1, SEL_CTRL, 8'h01);
        cfg(2'd2, SEL_CTRL, 8'h01);
        wait_idle("t2_timeout", 80);
        ea = '{8'h90, 8'hA0, 8'h91, 8'hA1};
        ed = '{pat(8'h20), pat(8'h30), pat(8'h21), pat(8'h31)};
        chk("t2_nwr", 32'(wa_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("t2_addr", 32'(wa_q[i]), 32'(ea[i]));
            chk("t2_data", 32'(wd_q[i]), 32'(ed[i]));
        end
        chk("t2_done1", 32'(done_cnt[1]), 32'd1);
        chk("t2_done2", 32'(done_cnt[2]), 32'd1);

        // Source address wraps; a CNT write while active is ignored.
        setup(2'd3, 8'hFE, 8'h40, 8'd4);
        clear_log();
        cfg(2'd3, SEL_CTRL, 8'h03);
        cfg(2'd3, SEL_CNT, 8'h20);
        wait_idle("t3_timeout", 60);
        ed = '{pat(8'hFE), pat(8'hFF), pat(8'h00), pat(8'h01)};
        chk("t3_nwr", 32'(wa_q.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            chk("t3_data", 32'(wd_q[i]), 32'(ed[i]));
        chk("t3_last_addr", 32'(wa_q[3]), 32'h43);
        chk("t3_done", 32'(done_cnt[3]), 32'd1);

        // Grant withheld, then dropped during the first WRITE.
        bus_gnt = 1'b0;
        setup(2'd0, 8'h50, 8'hC0, 8'd2);
        clear_log();
        cfg(2'd0, SEL_CTRL, 8'h03);
        repeat (5) @(negedge clk);
        chk("t4_wait_req", 32'(bus_req),      32'd1);
        chk("t4_wait_own", 32'(bus_own),      32'd0);
        chk("t4_wait_nwr", 32'(wa_q.size()),  32'd0);
        bus_gnt = 1'b1;
        begin
            int n = 0;
            while (!(bus_own && ram_addr == 8'hC0) && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("t4_find_write", 32'(n < 20), 32'd1);
        end
        bus_gnt = 1'b0;
        #1;
        chk("t4_suppress", 32'(ram_w_notr), 32'd0);
        @(negedge clk);
        chk("t4_retry_req", 32'(bus_req), 32'd1);
        chk("t4_retry_own", 32'(bus_own), 32'd0);
        bus_gnt = 1'b1;
        wait_idle("t4_timeout", 40);
        chk("t4_nwr",   32'(wa_q.size()), 32'd2);
        chk("t4_addr0", 32'(wa_q[0]),     32'hC0);
        chk("t4_data0", 32'(wd_q[0]),     32'(pat(8'h50)));
        chk("t4_addr1", 32'(wa_q[1]),     32'hC1);
        chk("t4_data1", 32'(wd_q[1]),     32'(pat(8'h51)));
        chk("t4_done",  32'(done_cnt[0]), 32'd2);
        chk("t4_nognt", 32'(wr_nognt),    32'd0);

        // START with CNT=0 (channel 2 drained earlier).
        cfg(2'd2, SEL_CTRL, 8'h01);
        chk("t5_done_hi", 32'(done[2]), 32'd1);
        chk("t5_busy",    32'(busy[2]), 32'd0);
        @(negedge clk);
        chk("t5_done_lo", 32'(done[2]), 32'd0);
        chk("t5_req",     32'(bus_req), 32'd0);
        @(negedge clk);
        chk("t5_req2",    32'(bus_req),     32'd0);
        chk("t5_count",   32'(done_cnt[2]), 32'd2);

        // Reset in the middle of a block transfer.
        setup(2'd1, 8'h60, 8'hD0, 8'd8);
        cfg(2'd1, SEL_CTRL, 8'h03);
        repeat (6) @(negedge clk);
        chk("t6_mid_own", 32'(bus_own), 32'd1);
        pre = done_cnt[1];
        rst = 1'b1;
        #1;
        chk("t6_rst_req",   32'(bus_req),    32'd0);
        chk("t6_rst_own",   32'(bus_own),    32'd0);
        chk("t6_rst_addr",  32'(ram_addr),   32'd0);
        chk("t6_rst_wnr",   32'(ram_w_notr), 32'd0);
        chk("t6_rst_wdata", 32'(ram_wdata),  32'd0);
        chk("t6_rst_busy",  32'(busy),       32'd0);
        chk("t6_rst_done",  32'(done),       32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("t6_no_done", 32'(done_cnt[1]), 32'(pre));
        chk("t6_busy",    32'(busy),        32'd0);
        chk("t6_req",     32'(bus_req),     32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
